// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM with mem handshake, timeout and trap
//
// Sequences FETCH/DECODE/EXEC/MEM/WB for each instruction and drives the shared
// datapath controls. Memory requests use a req/ack handshake with wait states;
// a request that waits MEM_TIMEOUT cycles without ack halts the FSM in TRAP,
// as does an illegal opcode. Retired instructions are counted modulo 2^CNT_W.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   opcode[5:0]                  IR[31:26], sampled in DECODE
//   mem_ack                      memory completes the current request
//   mem_req/mem_read/mem_write   memory request and direction
//   iord                         address mux (0=PC, 1=ALUOut)
//   ir_write, pc_write           IR / PC load enables
//   branch_eq, branch_neq        conditional PC loads
//   pc_src[1:0]                  00=ALU, 01=ALUOut, 10=jump target
//   alu_src_a, alu_src_b[1:0]    ALU operand muxes
//   alu_op[1:0]                  00=add, 01=sub, 10=funct
//   reg_dst, reg_write           register-file destination / write enable
//   mem_to_reg                   write-back source (1=MDR)
//   instr_done                   one-cycle retire pulse
//   retired[CNT_W-1:0]           retired-instruction count
//   trap, trap_cause[1:0]        halted flag and cause (01=illegal, 10=timeout)

module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch_eq,
  output logic             branch_neq,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  // Timer value during the last allowed waiting cycle; an un-acked cycle here traps.
  localparam logic [TW-1:0] LIMIT = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  state_t          state, state_n;
  logic [5:0]      op_q;
  logic [TW-1:0]   timer, timer_n;
  logic [1:0]      cause_q, cause_n;
  logic            timeout_hit;

  assign timeout_hit = (MEM_TIMEOUT != 0) && (timer == LIMIT);

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    cause_n    = cause_q;
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch_eq  = 1'b0;
    branch_neq = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    trap       = 1'b0;
    trap_cause = 2'b00;

    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // Ack wins over a timeout that would fire in the same cycle.
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_n  = DECODE;
        end else if (timeout_hit) begin
          state_n = TRAP;
          cause_n = 2'b10;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DECODE: begin
        // Precompute the branch target into ALUOut.
        alu_src_b = 2'b11;
        case (opcode)
          OP_J: begin
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            instr_done = 1'b1;
            state_n    = FETCH;
            timer_n    = '0;
          end
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: state_n = EXEC;
          default: begin
            state_n = TRAP;
            cause_n = 2'b01;
          end
        endcase
      end
      EXEC: begin
        alu_src_a = 1'b1;
        case (op_q)
          OP_R: begin
            alu_op  = 2'b10;
            state_n = WB;
          end
          OP_ADDI: begin
            alu_src_b = 2'b10;
            state_n   = WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b = 2'b10;
            state_n   = MEM;
            timer_n   = '0;
          end
          OP_BEQ, OP_BNE: begin
            alu_op     = 2'b01;
            pc_src     = 2'b01;
            branch_eq  = (op_q == OP_BEQ);
            branch_neq = (op_q == OP_BNE);
            instr_done = 1'b1;
            state_n    = FETCH;
            timer_n    = '0;
          end
          default: begin
            state_n = TRAP;
            cause_n = 2'b01;
          end
        endcase
      end
      MEM: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
        if (mem_ack) begin
          if (op_q == OP_LW) begin
            state_n = WB;
          end else begin
            instr_done = 1'b1;
            state_n    = FETCH;
            timer_n    = '0;
          end
        end else if (timeout_hit) begin
          state_n = TRAP;
          cause_n = 2'b10;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_q == OP_R);
        mem_to_reg = (op_q == OP_LW);
        instr_done = 1'b1;
        state_n    = FETCH;
        timer_n    = '0;
      end
      TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_q;
      end
      default: state_n = FETCH;
    endcase

    // Reset silences every control immediately so an aborted instruction
    // cannot complete a write in the reset cycle.
    if (rst) begin
      mem_req    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch_eq  = 1'b0;
      branch_neq = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      instr_done = 1'b0;
      trap       = 1'b0;
      trap_cause = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      op_q    <= '0;
      timer   <= '0;
      cause_q <= 2'b00;
      retired <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      cause_q <= cause_n;
      if (state == DECODE) op_q <= opcode;
      if (instr_done) retired <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl

module tb_multicycle_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode;
  logic          mem_ack;
  logic          mem_req, mem_read, mem_write, iord, ir_write, pc_write;
  logic          branch_eq, branch_neq, alu_src_a, reg_dst, reg_write;
  logic          mem_to_reg, instr_done, trap;
  logic [1:0]    pc_src, alu_src_b, alu_op, trap_cause;
  logic [CW-1:0] retired;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .branch_eq(branch_eq),
    .branch_neq(branch_neq), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
    .retired(retired), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_read, mem_write, iord, ir_write, pc_write;
    logic       branch_eq, branch_neq;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       reg_dst, reg_write, mem_to_reg, instr_done, trap;
    logic [1:0] trap_cause;
  } ctl_t;

  typedef enum {PH_F, PH_D, PH_E, PH_M, PH_W, PH_T, PH_Z} ph_t;

  int vectors     = 0;
  int miscompares = 0;
  int exp_retired = 0;

  logic [5:0] legal_ops [7] = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_J, OP_BEQ, OP_BNE};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t obs_ctl();
    ctl_t c;
    c = '{mem_req, mem_read, mem_write, iord, ir_write, pc_write, branch_eq,
          branch_neq, pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, reg_write,
          mem_to_reg, instr_done, trap, trap_cause};
    return c;
  endfunction

  // Expected controls for one cycle of an instruction phase.
  function automatic ctl_t exp_ctl(input ph_t p, input logic [5:0] op,
                                   input logic ack, input logic [1:0] cause);
    ctl_t c;
    c = '0;
    case (p)
      PH_F: begin
        c.mem_req = 1; c.mem_read = 1; c.alu_src_b = 2'b01;
        c.ir_write = ack; c.pc_write = ack;
      end
      PH_D: begin
        c.alu_src_b = 2'b11;
        if (op == OP_J) begin c.pc_write = 1; c.pc_src = 2'b10; c.instr_done = 1; end
      end
      PH_E: begin
        c.alu_src_a = 1;
        if (op == OP_R) c.alu_op = 2'b10;
        else if (op == OP_BEQ || op == OP_BNE) begin
          c.alu_op = 2'b01; c.pc_src = 2'b01; c.instr_done = 1;
          c.branch_eq = (op == OP_BEQ); c.branch_neq = (op == OP_BNE);
        end else c.alu_src_b = 2'b10;
      end
      PH_M: begin
        c.mem_req = 1; c.iord = 1;
        c.mem_read = (op == OP_LW); c.mem_write = (op == OP_SW);
        c.instr_done = ack && (op == OP_SW);
      end
      PH_W: begin
        c.reg_write = 1; c.reg_dst = (op == OP_R); c.mem_to_reg = (op == OP_LW);
        c.instr_done = 1;
      end
      PH_T: begin c.trap = 1; c.trap_cause = cause; end
      default: ;
    endcase
    return c;
  endfunction

  // Apply one cycle of inputs, compare outputs mid-cycle, then advance the retire model.
  task automatic cyc(input string tag, input logic r, input logic ack,
                     input logic [5:0] op, input ctl_t exp);
    rst = r; mem_ack = ack; opcode = op;
    @(negedge clk);
    check({tag, "/ctl"}, {10'b0, obs_ctl()}, {10'b0, exp});
    check({tag, "/retired"}, 32'(retired), 32'(exp_retired % (1 << CW)));
    @(posedge clk); #1;
    if (r) exp_retired = 0;
    else if (exp.instr_done) exp_retired++;
  endtask

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  task automatic fetch(input string tag, input logic [5:0] op, input int wf);
    for (int i = 0; i <= wf; i++)
      cyc({tag, "/fetch"}, 1'b0, (i == wf), rop(), exp_ctl(PH_F, op, (i == wf), 2'b00));
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input int wf, input int wm);
    fetch(tag, op, wf);
    cyc({tag, "/decode"}, 1'b0, rbit(), op, exp_ctl(PH_D, op, 1'b0, 2'b00));
    if (op == OP_J) return;
    // Opcode is scrambled after DECODE: later phases must use the latched copy.
    cyc({tag, "/exec"}, 1'b0, rbit(), rop(), exp_ctl(PH_E, op, 1'b0, 2'b00));
    if (op == OP_BEQ || op == OP_BNE) return;
    if (op == OP_LW || op == OP_SW) begin
      for (int i = 0; i <= wm; i++)
        cyc({tag, "/mem"}, 1'b0, (i == wm), rop(), exp_ctl(PH_M, op, (i == wm), 2'b00));
      if (op == OP_SW) return;
    end
    cyc({tag, "/wb"}, 1'b0, rbit(), rop(), exp_ctl(PH_W, op, 1'b0, 2'b00));
  endtask

  task automatic trap_cycles(input string tag, input int n, input logic [1:0] cause);
    for (int i = 0; i < n; i++)
      cyc({tag, "/trap"}, 1'b0, rbit(), rop(), exp_ctl(PH_T, 6'h0, 1'b0, cause));
  endtask

  task automatic reset_cycle(input string tag);
    cyc({tag, "/rst"}, 1'b1, rbit(), rop(), exp_ctl(PH_Z, 6'h0, 1'b0, 2'b00));
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; opcode = '0;
    @(posedge clk); #1;
    cyc("reset0", 1'b1, 1'b1, OP_ADDI, '0);
    cyc("reset1", 1'b1, 1'b1, OP_SW, '0);

    run_instr("addi", OP_ADDI, 0, 0);
    run_instr("lw_wait3", OP_LW, 0, 3);
    run_instr("beq", OP_BEQ, 0, 0);
    run_instr("bne", OP_BNE, 0, 0);
    run_instr("j", OP_J, 0, 0);
    run_instr("r", OP_R, 0, 0);
    run_instr("sw", OP_SW, 0, 0);
    run_instr("fetch_ack_on_limit", OP_ADDI, TO - 1, 0);
    run_instr("mem_ack_on_limit", OP_SW, 1, TO - 1);

    for (int n = 0; n < 40; n++)
      run_instr("rand", legal_ops[$urandom_range(0, 6)], $urandom_range(0, TO - 1),
                $urandom_range(0, TO - 1));

    // Illegal opcode: DECODE then sticky trap until reset.
    fetch("illegal", 6'h3f, 0);
    cyc("illegal/decode", 1'b0, 1'b0, 6'h3f, exp_ctl(PH_D, 6'h3f, 1'b0, 2'b00));
    trap_cycles("illegal", 20, 2'b01);
    reset_cycle("illegal");
    run_instr("after_illegal", OP_ADDI, 0, 0);

    fetch("illegal2", 6'h01, 1);
    cyc("illegal2/decode", 1'b0, 1'b1, 6'h01, exp_ctl(PH_D, 6'h01, 1'b0, 2'b00));
    trap_cycles("illegal2", 3, 2'b01);
    reset_cycle("illegal2");

    // Fetch timeout: TO waiting cycles with no ack.
    for (int i = 0; i < TO; i++)
      cyc("fetch_to/fetch", 1'b0, 1'b0, rop(), exp_ctl(PH_F, 6'h0, 1'b0, 2'b00));
    trap_cycles("fetch_to", 5, 2'b10);
    reset_cycle("fetch_to");

    // Memory timeout during a load.
    fetch("mem_to", OP_LW, 0);
    cyc("mem_to/decode", 1'b0, 1'b0, OP_LW, exp_ctl(PH_D, OP_LW, 1'b0, 2'b00));
    cyc("mem_to/exec", 1'b0, 1'b1, rop(), exp_ctl(PH_E, OP_LW, 1'b0, 2'b00));
    for (int i = 0; i < TO; i++)
      cyc("mem_to/mem", 1'b0, 1'b0, rop(), exp_ctl(PH_M, OP_LW, 1'b0, 2'b00));
    trap_cycles("mem_to", 4, 2'b10);
    reset_cycle("mem_to");

    // Reset in MEM of a store: ack arrives with reset, no write, no retire.
    run_instr("pre_sw", OP_R, 0, 0);
    fetch("sw_rst", OP_SW, 0);
    cyc("sw_rst/decode", 1'b0, 1'b0, OP_SW, exp_ctl(PH_D, OP_SW, 1'b0, 2'b00));
    cyc("sw_rst/exec", 1'b0, 1'b0, rop(), exp_ctl(PH_E, OP_SW, 1'b0, 2'b00));
    cyc("sw_rst/mem", 1'b0, 1'b0, rop(), exp_ctl(PH_M, OP_SW, 1'b0, 2'b00));
    cyc("sw_rst/rst", 1'b1, 1'b1, rop(), exp_ctl(PH_Z, 6'h0, 1'b0, 2'b00));
    run_instr("after_sw_rst", OP_ADDI, 0, 0);
    run_instr("final_lw", OP_LW, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
